// File: rtl/dqpsk_ble_pkg.sv
// Shared Bluetooth DQPSK definitions: Gray phase constants, nominal TX amplitudes,
// Gray<->phase-index helpers and the serialiser state type.
package dqpsk_ble_pkg;

  localparam int DIBIT_W = 2;

  localparam logic [1:0] PHASE_00 = 2'b00;
  localparam logic [1:0] PHASE_01 = 2'b01;
  localparam logic [1:0] PHASE_11 = 2'b11;
  localparam logic [1:0] PHASE_10 = 2'b10;

  // Nominal +/-362 constellation amplitude used by the transmit modulator.
  localparam logic [11:0] AMP_POS = 12'h16A;
  localparam logic [11:0] AMP_NEG = 12'hE96;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_BIT1 = 1'b1
  } ser_state_e;

  function automatic logic [1:0] gray_to_idx(input logic [1:0] gray);
    case (gray)
      PHASE_00: return 2'd0;
      PHASE_01: return 2'd1;
      PHASE_11: return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] idx_to_gray(input logic [1:0] idx);
    case (idx)
      2'd0:    return PHASE_00;
      2'd1:    return PHASE_01;
      2'd2:    return PHASE_11;
      default: return PHASE_10;
    endcase
  endfunction

endpackage

// File: rtl/dqpsk_ble_dibit_fifo.sv
// Synchronous FIFO holding decoded dibits; a pop on the same edge as a push
// to a full FIFO frees the slot so the push is accepted.
module dqpsk_ble_dibit_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every variable gets a default before the conditional updates so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dqpsk_demodulator_ble.sv
// Bluetooth DQPSK receive demodulator: sign slicer, differential decoder, dibit FIFO
// and one-bit-per-cycle serialiser. Define DQPSK_LOW_MAG_FLAG_EN to add the low_conf output.
module dqpsk_demodulator_ble
  import dqpsk_ble_pkg::*;
#(
  parameter int RE_IM_SIZE = 12,
  parameter int FIFO_DEPTH = 16
`ifdef DQPSK_LOW_MAG_FLAG_EN
  ,
  parameter logic [RE_IM_SIZE-1:0] LOW_MAG_THR = 12'd64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [RE_IM_SIZE-1:0] data_in_re,
  input  logic [RE_IM_SIZE-1:0] data_in_im,
  input  logic                  enable,
  output logic                  valid_out,
  output logic                  data_out,
  output logic                  overflow,
  output logic                  finished
`ifdef DQPSK_LOW_MAG_FLAG_EN
  ,
  output logic                  low_conf
`endif
);

`ifdef DQPSK_LOW_MAG_FLAG_EN
  localparam int FIFO_W = DIBIT_W + 1;

  // The most-negative input has no positive twin, so it saturates to full scale.
  function automatic logic [RE_IM_SIZE-1:0] abs_sat(input logic [RE_IM_SIZE-1:0] x);
    if (!x[RE_IM_SIZE-1]) return x;
    if (x == {1'b1, {(RE_IM_SIZE-1){1'b0}}}) return {1'b0, {(RE_IM_SIZE-1){1'b1}}};
    return ~x + RE_IM_SIZE'(1);
  endfunction

  logic low_mag;
  logic low_conf_q, low_conf_d;

  assign low_mag  = (abs_sat(data_in_re) < LOW_MAG_THR) || (abs_sat(data_in_im) < LOW_MAG_THR);
  assign low_conf = low_conf_q;
`else
  localparam int FIFO_W = DIBIT_W;

  logic unused_bits;
  assign unused_bits = ^{data_in_re[RE_IM_SIZE-2:0], data_in_im[RE_IM_SIZE-2:0]};
`endif

  ser_state_e        state_q, state_d;
  logic [1:0]        cur_sym, dibit, d_idx;
  logic [1:0]        prev_sym_q, prev_sym_d;
  logic [FIFO_W-1:0] fifo_wr, fifo_rd;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_W-2:0] pend_q, pend_d;
  logic              data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              overflow_q, overflow_d;
  logic              finished_q, finished_d;

  // Hard slice by sign; zero counts as positive.
  assign cur_sym = {data_in_re[RE_IM_SIZE-1], data_in_im[RE_IM_SIZE-1]};
  assign d_idx   = gray_to_idx(cur_sym) - gray_to_idx(prev_sym_q);
  assign dibit   = idx_to_gray(d_idx);

`ifdef DQPSK_LOW_MAG_FLAG_EN
  assign fifo_wr = {low_mag, dibit};
`else
  assign fifo_wr = dibit;
`endif

  dqpsk_ble_dibit_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (valid_in),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A gap cycle returns the phase reference to 00 so each burst decodes like the TX side.
  always_comb begin
    prev_sym_d = valid_in ? cur_sym : PHASE_00;
    overflow_d = overflow_q | (valid_in & fifo_full & ~fifo_pop);
    finished_d = ~valid_in & fifo_empty & (state_q == SER_IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE: if (enable && !fifo_empty) state_d = SER_BIT1;
      SER_BIT1: if (enable) state_d = SER_IDLE;
      default:  state_d = SER_IDLE;
    endcase
  end

  // pend holds the not-yet-emitted upper bit of the current dibit (plus its flag).
  always_comb begin
    fifo_pop    = 1'b0;
    pend_d      = pend_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
`ifdef DQPSK_LOW_MAG_FLAG_EN
    low_conf_d  = low_conf_q;
`endif
    case (state_q)
      SER_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop    = 1'b1;
          pend_d      = fifo_rd[FIFO_W-1:1];
          data_out_d  = fifo_rd[0];
          valid_out_d = 1'b1;
`ifdef DQPSK_LOW_MAG_FLAG_EN
          low_conf_d  = fifo_rd[FIFO_W-1];
`endif
        end
      end
      SER_BIT1: begin
        if (enable) begin
          data_out_d  = pend_q[0];
          valid_out_d = 1'b1;
`ifdef DQPSK_LOW_MAG_FLAG_EN
          low_conf_d  = pend_q[FIFO_W-2];
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sym_q  <= PHASE_00;
      pend_q      <= '0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      finished_q  <= 1'b1;
`ifdef DQPSK_LOW_MAG_FLAG_EN
      low_conf_q  <= 1'b0;
`endif
    end else begin
      prev_sym_q  <= prev_sym_d;
      pend_q      <= pend_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      finished_q  <= finished_d;
`ifdef DQPSK_LOW_MAG_FLAG_EN
      low_conf_q  <= low_conf_d;
`endif
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign overflow  = overflow_q;
  assign finished  = finished_q;

endmodule

// File: tb/tb_dqpsk_demodulator_ble.sv
// Directed bench for dqpsk_demodulator_ble: a per-cycle vector table plus hand-written
// backpressure, full-FIFO push/pop and (with DQPSK_LOW_MAG_FLAG_EN) low_conf sequences.
module tb_dqpsk_demodulator_ble;
  import dqpsk_ble_pkg::*;

  localparam logic [11:0] P    = AMP_POS;
  localparam logic [11:0] N    = AMP_NEG;
  localparam logic [11:0] Z    = 12'h000;
  localparam logic [11:0] MINV = 12'h800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] data_in_re = '0;
  logic [11:0] data_in_im = '0;
  logic        valid_out, data_out, overflow, finished;
`ifdef DQPSK_LOW_MAG_FLAG_EN
  logic        low_conf;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dqpsk_demodulator_ble dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in_re (data_in_re),
    .data_in_im (data_in_im),
    .enable     (enable),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .overflow   (overflow),
`ifdef DQPSK_LOW_MAG_FLAG_EN
    .low_conf   (low_conf),
`endif
    .finished   (finished)
  );

  // One row per clock: inputs for that edge and outputs expected just after it.
  typedef struct {
    logic        rst;
    logic        vin;
    logic [11:0] re;
    logic [11:0] im;
    logic        en;
    logic        ev;
    logic        cd;
    logic        ed;
    logic        ef;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vin, input logic [11:0] re,
                     input logic [11:0] im, input logic en, input logic ev,
                     input logic cd, input logic ed, input logic ef, input logic eo);
    vec_t v;
    v.rst = rst; v.vin = vin; v.re = re; v.im = im; v.en = en;
    v.ev = ev; v.cd = cd; v.ed = ed; v.ef = ef; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic vin, input logic [11:0] re,
                       input logic [11:0] im, input logic en);
    reset = rst; valid_in = vin; data_in_re = re; data_in_im = im; enable = en;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, Z, Z, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    int   nbits;
    logic b_prev1, b_prev2;
    logic exp_bit;

    // reset state
    add(1, 0, Z, Z, 1,    0, 1, 0, 1, 0);
    // single symbol cur=01 -> dibit 01 -> bits 1,0
    add(0, 1, P, N, 1,    0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    0, 0, 0, 1, 0);
    // burst cur 01,11,11,00 -> dibits 01,01,00,11 -> bits 1,0,1,0,0,0,1,1
    add(0, 1, P, N, 1,    0, 0, 0, 0, 0);
    add(0, 1, N, N, 1,    1, 1, 1, 0, 0);
    add(0, 1, N, N, 1,    1, 1, 0, 0, 0);
    add(0, 1, P, P, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    0, 0, 0, 1, 0);
    // gap: 11, idle, 11 -> both decode against 00 -> 11,11
    add(0, 1, N, N, 1,    0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 1, N, N, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    0, 0, 0, 1, 0);
    // enable stalls: cur 10 -> dibit 10 -> bits 0,1 with data held while stalled
    add(0, 1, N, P, 1,    0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 0,    0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 0,    0, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    0, 0, 0, 1, 0);
    // re=0, im=0x800 -> cur 01; reset lands mid-emission
    add(0, 1, Z, MINV, 1, 0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(1, 0, Z, Z, 1,    0, 1, 0, 1, 0);
    add(0, 0, Z, Z, 1,    0, 1, 0, 1, 0);
    // re=0x800, im=0 -> cur 10 -> bits 0,1
    add(0, 1, MINV, Z, 1, 0, 0, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 0, 0, 0);
    add(0, 0, Z, Z, 1,    1, 1, 1, 0, 0);
    add(0, 0, Z, Z, 1,    0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vin, vecs[i].re, vecs[i].im, vecs[i].en);
      step();
      check("vec.valid_out", i, 32'(valid_out), 32'(vecs[i].ev));
      check("vec.finished", i, 32'(finished), 32'(vecs[i].ef));
      check("vec.overflow", i, 32'(overflow), 32'(vecs[i].eo));
      if (vecs[i].cd) check("vec.data_out", i, 32'(data_out), 32'(vecs[i].ed));
    end

    // Backpressure: 20 symbols alternating cur 01/00 -> dibits 01,10,01,10,...
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, P, (i % 2 == 0) ? N : P, 1'b0);
      step();
      check("bp.valid_out", i, 32'(valid_out), 32'd0);
      if (i == 15) check("bp.overflow_at_16", i, 32'(overflow), 32'd0);
      if (i == 16) check("bp.overflow_at_17", i, 32'(overflow), 32'd1);
    end
    drive(1'b0, 1'b0, Z, Z, 1'b1);
    for (int j = 0; j < 32; j++) begin
      step();
      exp_bit = ((j / 2) % 2) == (j % 2);
      check("bp.drain_valid", j, 32'(valid_out), 32'd1);
      check("bp.drain_bit", j, 32'(data_out), 32'(exp_bit));
    end
    step();
    check("bp.after_valid", 0, 32'(valid_out), 32'd0);
    check("bp.after_finished", 0, 32'(finished), 32'd1);
    check("bp.overflow_sticky", 0, 32'(overflow), 32'd1);
    do_reset();
    check("bp.overflow_cleared", 0, 32'(overflow), 32'd0);

    // Push on a full FIFO while the serialiser pops: accepted, 17 dibits drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, P, N, 1'b0);
      step();
    end
    drive(1'b0, 1'b1, P, P, 1'b1);
    step();
    check("full_pp.overflow", 0, 32'(overflow), 32'd0);
    check("full_pp.first_valid", 0, 32'(valid_out), 32'd1);
    check("full_pp.first_bit", 0, 32'(data_out), 32'd1);
    drive(1'b0, 1'b0, Z, Z, 1'b1);
    nbits = 1;
    b_prev1 = 1'b0;
    b_prev2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (valid_out) begin
        nbits++;
        b_prev2 = b_prev1;
        b_prev1 = data_out;
      end
    end
    check("full_pp.bit_count", 0, 32'(nbits), 32'd34);
    check("full_pp.last_dibit", 0, 32'({b_prev2, b_prev1}), 32'b01);
    check("full_pp.finished", 0, 32'(finished), 32'd1);
    check("full_pp.overflow_end", 0, 32'(overflow), 32'd0);

`ifdef DQPSK_LOW_MAG_FLAG_EN
    // Weak re (0x030) flags both bits of its symbol; a nominal symbol does not.
    do_reset();
    check("lc.reset", 0, 32'(low_conf), 32'd0);
    drive(1'b0, 1'b1, 12'h030, P, 1'b1);
    step();
    drive(1'b0, 1'b1, P, N, 1'b1);
    step();
    check("lc.sym0_b0_flag", 0, 32'(low_conf), 32'd1);
    check("lc.sym0_b0_bit", 0, 32'(data_out), 32'd0);
    drive(1'b0, 1'b0, Z, Z, 1'b1);
    step();
    check("lc.sym0_b1_flag", 0, 32'(low_conf), 32'd1);
    check("lc.sym0_b1_bit", 0, 32'(data_out), 32'd0);
    step();
    check("lc.sym1_b0_flag", 0, 32'(low_conf), 32'd0);
    check("lc.sym1_b0_bit", 0, 32'(data_out), 32'd1);
    step();
    check("lc.sym1_b1_flag", 0, 32'(low_conf), 32'd0);
    check("lc.sym1_b1_bit", 0, 32'(data_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
